// File: rtl/fft_stream_host.sv
// Host-side driver for the fft accelerator's AXI-Stream ports: buffers one input frame,
// streams it out with tlast, pulses start, then captures the result frame for host readback.
module fft_stream_host #(
   parameter  int SIZE       = 8,
   parameter  int DATA_WIDTH = 32,
   localparam int ADDR_W     = $clog2(SIZE)
) (
   input  logic                      s00_axi_aclk,
   input  logic                      s00_axi_aresetn,
   input  logic                      wr_en,
   input  logic [ADDR_W-1:0]         wr_addr,
   input  logic [DATA_WIDTH-1:0]     wr_data,
   input  logic [ADDR_W-1:0]         rd_addr,
   output logic [DATA_WIDTH-1:0]     rd_data,
   input  logic                      go,
   output logic                      busy,
   output logic                      done,
   output logic                      err_len,
   output logic                      m00_axis_tvalid,
   output logic [DATA_WIDTH-1:0]     m00_axis_tdata,
   output logic [DATA_WIDTH/8-1:0]   m00_axis_tstrb,
   output logic                      m00_axis_tlast,
   input  logic                      m00_axis_tready,
   output logic                      start,
   input  logic                      s00_axis_tvalid,
   input  logic [DATA_WIDTH-1:0]     s00_axis_tdata,
   input  logic                      s00_axis_tlast,
   output logic                      s00_axis_tready
);

   typedef enum logic [2:0] {IDLE, SEND, START, RECV, DONE} state_t;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(SIZE - 1);

   state_t                  state;
   logic [ADDR_W-1:0]       idx;
   logic [ADDR_W-1:0]       idx_nxt;
   logic                    idx_last;
   logic                    send_beat;
   logic                    recv_beat;
   logic [DATA_WIDTH-1:0]   first_word;
   logic [DATA_WIDTH-1:0]   in_buf  [SIZE];
   logic [DATA_WIDTH-1:0]   out_buf [SIZE];

   assign idx_nxt        = idx + ADDR_W'(1);
   assign idx_last       = (idx == LAST_IDX);
   assign send_beat      = (state == SEND) && m00_axis_tvalid && m00_axis_tready;
   assign recv_beat      = (state == RECV) && s00_axis_tready && s00_axis_tvalid;
   assign m00_axis_tstrb = '1;

   // A write to word 0 in the same cycle as go must reach the first streamed beat.
   assign first_word = (wr_en && (wr_addr == '0)) ? wr_data : in_buf[0];

   always_ff @(posedge s00_axi_aclk) begin
      if (wr_en && !busy)
         in_buf[wr_addr] <= wr_data;
   end

   always_ff @(posedge s00_axi_aclk) begin
      if (recv_beat)
         out_buf[idx] <= s00_axis_tdata;
   end

   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn)
         rd_data <= '0;
      else
         rd_data <= out_buf[rd_addr];
   end

   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         state           <= IDLE;
         idx             <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         err_len         <= 1'b0;
         start           <= 1'b0;
         m00_axis_tvalid <= 1'b0;
         m00_axis_tlast  <= 1'b0;
         m00_axis_tdata  <= '0;
         s00_axis_tready <= 1'b0;
      end else begin
         done  <= 1'b0;
         start <= 1'b0;
         unique case (state)
            IDLE: begin
               if (go) begin
                  state           <= SEND;
                  idx             <= '0;
                  err_len         <= 1'b0;
                  busy            <= 1'b1;
                  m00_axis_tvalid <= 1'b1;
                  m00_axis_tdata  <= first_word;
                  m00_axis_tlast  <= 1'b0;
               end
            end
            SEND: begin
               if (send_beat) begin
                  if (idx_last) begin
                     state           <= START;
                     idx             <= '0;
                     start           <= 1'b1;
                     m00_axis_tvalid <= 1'b0;
                     m00_axis_tlast  <= 1'b0;
                     m00_axis_tdata  <= '0;
                  end else begin
                     idx             <= idx_nxt;
                     m00_axis_tdata  <= in_buf[idx_nxt];
                     m00_axis_tlast  <= (idx_nxt == LAST_IDX);
                  end
               end
            end
            START: begin
               state           <= RECV;
               s00_axis_tready <= 1'b1;
            end
            RECV: begin
               if (recv_beat) begin
                  // Full-length frame ends on slot SIZE-1; an early tlast ends it short.
                  if (idx_last) begin
                     state           <= DONE;
                     idx             <= '0;
                     done            <= 1'b1;
                     s00_axis_tready <= 1'b0;
                     err_len         <= ~s00_axis_tlast;
                  end else if (s00_axis_tlast) begin
                     state           <= DONE;
                     idx             <= '0;
                     done            <= 1'b1;
                     s00_axis_tready <= 1'b0;
                     err_len         <= 1'b1;
                  end else begin
                     idx             <= idx_nxt;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
